vdc_pixelgen: RTL

Consumer end of the VDC RAM fetch path. It reads the screen, attribute and character latches that the RAM interface fills, and serializes them into a 4-bit RGBI pixel stream. Text-mode attribute handling (reverse, underline, blink, cursor) and horizontal character geometry are applied here. Output feeds the video timing/sync stage.

---
 rtl/vdc_pixelgen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vdc_pixelgen.sv
// rtl/vdc_pixelgen.sv - VDC pixel generator: latch readout, text attributes, RGBI serializer
module vdc_pixelgen #(
  parameter int C_LATCH_WIDTH = 8,
  parameter int S_LATCH_WIDTH = 82,
  parameter int C_LATCH_BITS  = $clog2(C_LATCH_WIDTH),
  parameter int S_LATCH_BITS  = $clog2(S_LATCH_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [3:0]                   reg_cth,
  input  logic [3:0]                   reg_cdh,
  input  logic                         reg_dbl,
  input  logic                         reg_text,
  input  logic                         reg_atr,
  input  logic                         reg_rvs,
  input  logic [3:0]                   reg_fg,
  input  logic [3:0]                   reg_bg,
  input  logic [4:0]                   reg_ul,
  input  logic [1:0]                   reg_cm,
  input  logic [4:0]                   reg_cs,
  input  logic [4:0]                   reg_ce,
  input  logic [15:0]                  reg_cp,
  input  logic [1:0]                   newFrame,
  input  logic                         newLine,
  input  logic                         newCol,
  input  logic                         hVisible,
  input  logic                         vVisible,
  input  logic                         blank,
  input  logic [4:0]                   line,
  input  logic                         rowbuf,
  // bank-major packing: byte (bank*S_LATCH_WIDTH + column) sits at bits [8*idx +: 8]
  input  logic [16*S_LATCH_WIDTH-1:0]  attrbuf,
  // byte i of the character latch sits at bits [8*i +: 8]
  input  logic [8*C_LATCH_WIDTH-1:0]   charbuf,
  input  logic [15:0]                  dispaddr,
  output logic [3:0]                   rgbi
);

  localparam int AE = $clog2(2 * S_LATCH_WIDTH);
  localparam logic [C_LATCH_BITS-1:0] CI_LAST   = C_LATCH_BITS'(C_LATCH_WIDTH - 1);
  localparam logic [S_LATCH_BITS-1:0] CIDX_LAST = S_LATCH_BITS'(S_LATCH_WIDTH - 1);

  logic [7:0]              shifter, shifter_n;
  logic [3:0]              px, px_n;
  logic                    dup, dup_n;
  logic [S_LATCH_BITS-1:0] cidx, cidx_n, cidx_use;
  logic [C_LATCH_BITS-1:0] ci, ci_n, ci_use;
  logic [4:0]              fc;
  logic [7:0]              attr, attr_n;
  logic                    cursor, cursor_n;

  logic                    in_window;
  logic                    load;
  logic [AE-1:0]           attr_ent;
  logic [7:0]              char_sel;
  logic [7:0]              attr_sel;
  logic                    cursor_phase;
  logic                    cursor_hit;
  logic                    pix_bit;
  logic [3:0]              rgbi_n;

  assign in_window = hVisible && vVisible;
  assign load      = newCol && !dup;
  assign cidx_use  = newLine ? '0 : cidx;
  assign ci_use    = newLine ? '0 : ci;
  assign attr_ent  = AE'(rowbuf ? S_LATCH_WIDTH : 0) + AE'(cidx_use);
  assign char_sel  = charbuf[{ci_use, 3'b000} +: 8];
  assign attr_sel  = attrbuf[{attr_ent, 3'b000} +: 8];

  // cursor visibility for the current frame count
  always_comb begin
    cursor_phase = 1'b0;
    case (reg_cm)
      2'b00:   cursor_phase = 1'b1;
      2'b01:   cursor_phase = 1'b0;
      2'b10:   cursor_phase = !fc[3];
      default: cursor_phase = !fc[4];
    endcase
  end

  assign cursor_hit = !reg_text
                   && ((dispaddr + {{(16-S_LATCH_BITS){1'b0}}, cidx_use}) == reg_cp)
                   && (reg_cs <= line) && (line <= reg_ce)
                   && cursor_phase;

  // next cell/shift state; the output pixel is taken from this so pixel 0 leaves with the load
  always_comb begin
    shifter_n = shifter;
    px_n      = px;
    dup_n     = dup;
    attr_n    = attr;
    cursor_n  = cursor;
    cidx_n    = cidx;
    ci_n      = ci;
    if (load) begin
      // the load enable is the first half of a doubled pixel
      dup_n  = reg_dbl;
      px_n   = 4'd0;
      cidx_n = cidx_use;
      ci_n   = ci_use;
      if (in_window) begin
        shifter_n = char_sel;
        ci_n      = (ci_use == CI_LAST) ? '0 : ci_use + 1'b1;
        attr_n    = reg_atr ? attr_sel : {4'b0000, reg_fg};
        cursor_n  = cursor_hit;
        cidx_n    = (cidx_use == CIDX_LAST) ? cidx_use : cidx_use + 1'b1;
      end else begin
        shifter_n = 8'h00;
      end
    end else begin
      dup_n = reg_dbl ? !dup : 1'b0;
      if (!reg_dbl || !dup) begin
        shifter_n = {shifter[6:0], 1'b0};
        if (px < reg_cth) px_n = px + 4'd1;
      end
    end
  end

  // pixel bit with text attributes, then colour and blanking selection
  always_comb begin
    pix_bit = shifter_n[7] && (px_n <= reg_cdh);
    if (!reg_text) begin
      if (attr_n[5] && (line == reg_ul)) pix_bit = 1'b1;
      if (attr_n[4] && fc[4])            pix_bit = 1'b0;
      pix_bit = pix_bit ^ attr_n[6] ^ reg_rvs ^ cursor_n;
    end else begin
      pix_bit = pix_bit ^ attr_n[6] ^ reg_rvs;
    end
    if (blank)           rgbi_n = 4'h0;
    else if (!in_window) rgbi_n = reg_bg;
    else if (pix_bit)    rgbi_n = attr_n[3:0];
    else                 rgbi_n = reg_bg;
  end

  // state registers, advanced only on pixel enables
  always_ff @(posedge clk) begin
    if (reset) begin
      shifter <= 8'h00;
      px      <= 4'd0;
      dup     <= 1'b0;
      cidx    <= '0;
      ci      <= '0;
      fc      <= 5'd0;
      attr    <= 8'h00;
      cursor  <= 1'b0;
      rgbi    <= 4'h0;
    end else if (enable) begin
      shifter <= shifter_n;
      px      <= px_n;
      dup     <= dup_n;
      cidx    <= cidx_n;
      ci      <= ci_n;
      attr    <= attr_n;
      cursor  <= cursor_n;
      rgbi    <= rgbi_n;
      if (newFrame != 2'b00) fc <= fc + 5'd1;
    end
  end

endmodule
